// File: rtl/sprite_bus_arbiter.sv
// Round-robin owner of the shared sprite-memory data bus: drives the bus for the
// current owner, captures read data, and enforces a hold limit and a turnaround gap.
module sprite_bus_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS-1:0]       drive,
  input  logic [CHANNELS*WIDTH-1:0] wdata,
  output logic [CHANNELS-1:0]       grant,
  output logic                      busy,
  output logic [WIDTH-1:0]          rdata,
  inout  wire  [WIDTH-1:0]          bus
);

  localparam int unsigned OW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned HW = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned TW = ($clog2(TURNAROUND + 1) > 0) ? $clog2(TURNAROUND + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t              state, state_n;
  logic [OW-1:0]       last_owner, last_owner_n;
  logic [HW-1:0]       hold, hold_n, hold_inc;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [CHANNELS-1:0] grant_n;
  logic                busy_n;
  logic [WIDTH-1:0]    rdata_n;
  logic [OW-1:0]       pick;
  int                  cand;
  logic                owner_req;
  logic                others_req;
  logic                bus_en;
  logic [WIDTH-1:0]    owner_data;

  // Round-robin pick: descending scan so the smallest offset from last_owner wins.
  always_comb begin
    pick = last_owner;
    cand = 0;
    for (int k = int'(CHANNELS); k >= 1; k--) begin
      cand = (int'(last_owner) + k) % int'(CHANNELS);
      if (req[cand]) pick = OW'(cand);
    end
  end

  // grant is one-hot while owning, so it doubles as the owner mask.
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);
  assign bus_en     = |(grant & drive);
  assign hold_inc   = (hold == HOLD_MAX) ? hold : hold + HW'(1);

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant[i]) owner_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  // One tristate buffer per bus bit; released whenever no owner is writing.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_buf
    assign bus[i] = bus_en ? owner_data[i] : 1'bz;
  end

  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    hold_n       = hold;
    tcnt_n       = tcnt;
    grant_n      = grant;
    rdata_n      = rdata;
    case (state)
      IDLE: begin
        if (|req) begin
          last_owner_n = pick;
          hold_n       = '0;
          grant_n      = CHANNELS'(1) << pick;
          state_n      = OWN;
        end
      end
      OWN: begin
        hold_n = hold_inc;
        if (!bus_en) rdata_n = bus;
        // Hold limit only forces a release when someone else is waiting.
        if (!owner_req || (hold_inc == HOLD_MAX && others_req)) begin
          grant_n = '0;
          if (TURNAROUND == 0) begin
            state_n = IDLE;
          end else begin
            state_n = TURN;
            tcnt_n  = TURN_LOAD;
          end
        end
      end
      TURN: begin
        tcnt_n = tcnt - TW'(1);
        if (tcnt <= TW'(1)) begin
          tcnt_n  = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OW'(CHANNELS - 1);
      hold       <= '0;
      tcnt       <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      rdata      <= '0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      hold       <= hold_n;
      tcnt       <= tcnt_n;
      grant      <= grant_n;
      busy       <= busy_n;
      rdata      <= rdata_n;
    end
  end

endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Scoreboard bench for sprite_bus_arbiter: two instances (turnaround 1 and 0) share
// stimulus; an ownership-level reference model predicts grant/busy/rdata/bus per cycle.
module tb_sprite_bus_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned MH = 4;
  localparam int NC = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [CH-1:0]      req;
  logic [CH-1:0]      drive;
  logic [CH*W-1:0]    wdata;
  logic [CH-1:0]      grant_o [NC];
  logic               busy_o  [NC];
  logic [W-1:0]       rdata_o [NC];
  wire  [W-1:0]       bus0;
  wire  [W-1:0]       bus1;
  logic [NC-1:0]      tb_en;
  logic [W-1:0]       tb_val;

  assign bus0 = tb_en[0] ? tb_val : {W{1'bz}};
  assign bus1 = tb_en[1] ? tb_val : {W{1'bz}};

  always #5 clk = ~clk;

  sprite_bus_arbiter #(.WIDTH(W), .CHANNELS(CH), .TURNAROUND(1), .MAX_HOLD(MH)) dut0 (
    .clk(clk), .reset(reset), .req(req), .drive(drive), .wdata(wdata),
    .grant(grant_o[0]), .busy(busy_o[0]), .rdata(rdata_o[0]), .bus(bus0)
  );

  sprite_bus_arbiter #(.WIDTH(W), .CHANNELS(CH), .TURNAROUND(0), .MAX_HOLD(MH)) dut1 (
    .clk(clk), .reset(reset), .req(req), .drive(drive), .wdata(wdata),
    .grant(grant_o[1]), .busy(busy_o[1]), .rdata(rdata_o[1]), .bus(bus1)
  );

  typedef struct packed {
    logic [CH-1:0] grant;
    logic          busy;
    logic [W-1:0]  rdata;
    logic          rel;
    logic [W-1:0]  bus;
  } obs_t;
  typedef obs_t [NC-1:0] rec_t;

  rec_t sb[$];
  int checks = 0;
  int fails  = 0;

  // Reference model: current owner (-1 = none), cycles owned, remaining gap cycles.
  int         m_owner [NC];
  int         m_held  [NC];
  int         m_gap   [NC];
  int         m_last  [NC];
  logic [W-1:0] m_rdata [NC];

  function automatic int ta(int c);
    return (c == 0) ? 1 : 0;
  endfunction

  function automatic logic [W-1:0] bus_of(int c);
    return (c == 0) ? bus0 : bus1;
  endfunction

  function automatic bit released(logic [W-1:0] v);
    return $isunknown(v) || (v == '0);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_owner[c] = -1;
      m_held[c]  = 0;
      m_gap[c]   = 0;
      m_last[c]  = CH - 1;
      m_rdata[c] = '0;
    end
  endfunction

  function automatic void model_advance(int c, logic [CH-1:0] r, logic [CH-1:0] d,
                                        logic [W-1:0] seen);
    int o;
    bit others;
    bit found;
    o = m_owner[c];
    if (o >= 0) begin
      if (!d[o]) m_rdata[c] = seen;
      others = 1'b0;
      for (int k = 0; k < CH; k++) if (k != o && r[k]) others = 1'b1;
      if (!r[o] || (m_held[c] >= MH && others)) begin
        m_owner[c] = -1;
        m_gap[c]   = ta(c);
      end else if (m_held[c] < MH) begin
        m_held[c]++;
      end
    end else if (m_gap[c] > 0) begin
      m_gap[c]--;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= CH; k++) begin
        if (!found && r[(m_last[c] + k) % CH]) begin
          found      = 1'b1;
          m_owner[c] = (m_last[c] + k) % CH;
          m_last[c]  = m_owner[c];
          m_held[c]  = 1;
        end
      end
    end
  endfunction

  function automatic void verdict(string name, int c, bit ok, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, c, act, exp, $time);
    end
  endfunction

  function automatic logic [CH*W-1:0] wd1(int ch, logic [W-1:0] v);
    logic [CH*W-1:0] x;
    x = CH*W'($urandom);
    x[ch*W +: W] = v;
    return x;
  endfunction

  // One clock of stimulus: advance the model over the edge, apply new inputs, queue expectations.
  task automatic cycle(input logic [CH-1:0] r, input logic [CH-1:0] d,
                       input logic [CH*W-1:0] wd, input logic [W-1:0] tv);
    rec_t rec;
    int o;
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) model_advance(c, req, drive, tb_val);
    req    = r;
    drive  = d;
    wdata  = wd;
    tb_val = tv;
    for (int c = 0; c < NC; c++) begin
      o = m_owner[c];
      tb_en[c]       = (o >= 0) && !d[o];
      rec[c].grant   = (o >= 0) ? (CH'(1) << o) : '0;
      rec[c].busy    = (o >= 0) || (m_gap[c] > 0);
      rec[c].rdata   = m_rdata[c];
      rec[c].rel     = (o < 0);
      rec[c].bus     = (o < 0) ? '0 : (d[o] ? wd[o*W +: W] : tv);
    end
    sb.push_back(rec);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    tb_en = '0;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  // Monitor: reset values while reset is high, otherwise one queued expectation per cycle.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        for (int c = 0; c < NC; c++) begin
          verdict("reset_grant", c, grant_o[c] == '0, 32'(grant_o[c]), 32'd0);
          verdict("reset_busy",  c, busy_o[c] == 1'b0, 32'(busy_o[c]), 32'd0);
          verdict("reset_rdata", c, rdata_o[c] == '0, 32'(rdata_o[c]), 32'd0);
          verdict("reset_bus",   c, released(bus_of(c)), 32'(bus_of(c)), 32'd0);
        end
      end else if (sb.size() > 0) begin
        r = sb.pop_front();
        for (int c = 0; c < NC; c++) begin
          verdict("grant",   c, grant_o[c] === r[c].grant, 32'(grant_o[c]), 32'(r[c].grant));
          verdict("onehot0", c, $onehot0(grant_o[c]), 32'(grant_o[c]), 32'(r[c].grant));
          verdict("busy",    c, busy_o[c] === r[c].busy, 32'(busy_o[c]), 32'(r[c].busy));
          verdict("rdata",   c, rdata_o[c] === r[c].rdata, 32'(rdata_o[c]), 32'(r[c].rdata));
          if (r[c].rel)
            verdict("bus_release", c, released(bus_of(c)), 32'(bus_of(c)), 32'd0);
          else
            verdict("bus_value", c, bus_of(c) === r[c].bus, 32'(bus_of(c)), 32'(r[c].bus));
        end
      end
    end
  end

  initial begin
    logic [CH-1:0] rr;
    reset  = 1'b1;
    req    = '0;
    drive  = '0;
    wdata  = '0;
    tb_en  = '0;
    tb_val = '0;
    rr     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Single write by ch0, then ch1 waiting while ch0 releases.
    repeat (3) cycle(4'b0001, 4'b0001, wd1(0, 8'h3C), 8'h00);
    repeat (2) cycle(4'b0011, 4'b0001, wd1(0, 8'h3C), 8'h00);
    // ch1 reads the bench-driven 5A, then switches to writing and rdata must hold.
    repeat (5) cycle(4'b0010, 4'b0000, wd1(1, 8'h11), 8'h5A);
    repeat (3) cycle(4'b0010, 4'b0010, wd1(1, 8'h77), 8'h00);
    repeat (4) cycle(4'b0000, 4'b0000, wd1(0, 8'h00), 8'h00);
    // Sole requester keeps the bus past the hold limit, then yields once ch0 asks.
    repeat (14) cycle(4'b1000, 4'b1000, wd1(3, 8'hC3), 8'h00);
    repeat (8) cycle(4'b1001, 4'b1001, CH*W'($urandom), 8'h00);
    // All channels requesting: round robin with hold limit.
    repeat (40) cycle(4'b1111, 4'b1111, CH*W'($urandom), 8'h00);
    // ch2 owns and drives A5, then asynchronous reset mid-ownership.
    repeat (6) cycle(4'b0100, 4'b0100, wd1(2, 8'hA5), 8'h00);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr = CH'($urandom);
      cycle(rr, CH'($urandom), CH*W'($urandom), W'($urandom));
    end
    repeat (4) cycle(4'b0000, 4'b0000, '0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
